// File: rtl/cassette_player_if.sv
// Byte-fetch bus between the cassette player and its tape store.
interface cassette_player_if;
  logic        rd_req;
  logic [23:0] rd_addr;
  logic        rd_ack;
  logic [7:0]  rd_data;

  modport master (
    output rd_req, rd_addr,
    input  rd_ack, rd_data
  );

  modport slave (
    input  rd_req, rd_addr,
    output rd_ack, rd_data
  );
endinterface

// File: rtl/cassette_player.sv
// Streams tape bytes as FSK half-period pulses, LSB first.
// Optional leader tone before the first byte: CASSETTE_LEADER_EN.
module cassette_player #(
  parameter int ZERO_HALF     = 8,
  parameter int ONE_HALF      = 4,
  parameter int LEADER_CYCLES = 256
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        play,
  input  logic        rewind,
  input  logic        ce_tick,
  input  logic [23:0] tape_end,
  output logic        rd_req,
  output logic [23:0] rd_addr,
  input  logic        rd_ack,
  input  logic [7:0]  rd_data,
  output logic        cass_out,
  output logic [23:0] pos,
  output logic        playing,
  output logic        done
);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    BIT_HI,
    BIT_LO
`ifdef CASSETTE_LEADER_EN
    , LEADER
`endif
  } state_t;

  localparam logic [7:0] ZH = 8'(ZERO_HALF);
  localparam logic [7:0] OH = 8'(ONE_HALF);

  state_t      state_q, state_d;
  logic [23:0] pos_q, pos_d;
  logic [23:0] addr_q, addr_d;
  logic [7:0]  byte_q, byte_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  tick_q, tick_d;
  logic        held_q, held_d;
  logic        discard_q, discard_d;
  logic        done_q, done_d;

  logic [7:0]  half;
  logic [7:0]  tick_inc;
  logic        half_end;

`ifdef CASSETTE_LEADER_EN
  localparam logic [15:0] LC_LAST = 16'(LEADER_CYCLES - 1);
  logic [15:0] lead_cnt_q, lead_cnt_d;
  logic        lead_lo_q, lead_lo_d;
  logic        lead_held_q, lead_held_d;
  logic        skip_q, skip_d;
  logic        lead_end;
`else
  logic        unused_leader_cycles;
  assign unused_leader_cycles = (LEADER_CYCLES == 0);
`endif

  assign tick_inc = tick_q + 8'd1;
  assign half     = byte_q[bit_q] ? OH : ZH;
  assign half_end = ce_tick && (tick_inc == half);
`ifdef CASSETTE_LEADER_EN
  assign lead_end = ce_tick && (tick_inc == OH);
`endif

  always_comb begin
    state_d   = state_q;
    pos_d     = pos_q;
    byte_d    = byte_q;
    bit_d     = bit_q;
    tick_d    = tick_q;
    held_d    = held_q;
    discard_d = discard_q;
    done_d    = 1'b0;
`ifdef CASSETTE_LEADER_EN
    lead_cnt_d  = lead_cnt_q;
    lead_lo_d   = lead_lo_q;
    lead_held_d = lead_held_q;
    skip_d      = skip_q;
`endif
    if (discard_q && rd_ack) discard_d = 1'b0;

    if (rewind) begin
      state_d   = IDLE;
      pos_d     = '0;
      bit_d     = '0;
      tick_d    = '0;
      held_d    = 1'b0;
      // an outstanding fetch must still be acked, then dropped
      discard_d = (discard_q || state_q == FETCH) && !rd_ack;
`ifdef CASSETTE_LEADER_EN
      lead_cnt_d  = '0;
      lead_lo_d   = 1'b0;
      lead_held_d = 1'b0;
      skip_d      = 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (play && !discard_q) begin
            if (held_q) begin
              held_d  = 1'b0;
              state_d = BIT_HI;
            end
`ifdef CASSETTE_LEADER_EN
            else if (lead_held_q) begin
              lead_held_d = 1'b0;
              state_d     = LEADER;
            end else if (pos_q == '0 && !skip_q) begin
              lead_cnt_d = '0;
              lead_lo_d  = 1'b0;
              tick_d     = '0;
              state_d    = LEADER;
            end
`endif
            else begin
              state_d = FETCH;
            end
          end
        end
        FETCH: begin
          if (rd_ack) begin
            byte_d  = rd_data;
            bit_d   = '0;
            tick_d  = '0;
            state_d = play ? BIT_HI : IDLE;
            held_d  = !play;
          end
        end
        BIT_HI: begin
          if (half_end) begin
            tick_d  = '0;
            state_d = BIT_LO;
          end else if (ce_tick) begin
            tick_d = tick_inc;
          end
        end
        BIT_LO: begin
          if (half_end) begin
            tick_d = '0;
            if (bit_q == 3'd7) begin
              bit_d = '0;
              if (pos_q == tape_end) begin
                pos_d   = '0;
                done_d  = 1'b1;
                state_d = IDLE;
`ifdef CASSETTE_LEADER_EN
                skip_d  = 1'b0;
`endif
              end else begin
                pos_d   = pos_q + 24'd1;
                state_d = play ? FETCH : IDLE;
              end
            end else begin
              bit_d   = bit_q + 3'd1;
              state_d = play ? BIT_HI : IDLE;
              held_d  = !play;
            end
          end else if (ce_tick) begin
            tick_d = tick_inc;
          end
        end
`ifdef CASSETTE_LEADER_EN
        LEADER: begin
          if (lead_end) begin
            tick_d    = '0;
            lead_lo_d = !lead_lo_q;
            if (lead_lo_q) begin
              if (lead_cnt_q == LC_LAST) begin
                lead_cnt_d = '0;
                skip_d     = 1'b1;
                state_d    = play ? FETCH : IDLE;
              end else begin
                lead_cnt_d  = lead_cnt_q + 16'd1;
                state_d     = play ? LEADER : IDLE;
                lead_held_d = !play;
              end
            end
          end else if (ce_tick) begin
            tick_d = tick_inc;
          end
        end
`endif
        default: state_d = IDLE;
      endcase
    end

    addr_d = discard_d ? addr_q : pos_d;
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      pos_q     <= '0;
      addr_q    <= '0;
      byte_q    <= '0;
      bit_q     <= '0;
      tick_q    <= '0;
      held_q    <= 1'b0;
      discard_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pos_q     <= pos_d;
      addr_q    <= addr_d;
      byte_q    <= byte_d;
      bit_q     <= bit_d;
      tick_q    <= tick_d;
      held_q    <= held_d;
      discard_q <= discard_d;
      done_q    <= done_d;
    end
  end

`ifdef CASSETTE_LEADER_EN
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      lead_cnt_q  <= '0;
      lead_lo_q   <= 1'b0;
      lead_held_q <= 1'b0;
      skip_q      <= 1'b0;
    end else begin
      lead_cnt_q  <= lead_cnt_d;
      lead_lo_q   <= lead_lo_d;
      lead_held_q <= lead_held_d;
      skip_q      <= skip_d;
    end
  end

  assign cass_out = (state_q == BIT_HI) ||
                    (state_q == LEADER && !lead_lo_q);
`else
  assign cass_out = (state_q == BIT_HI);
`endif

  assign rd_req  = (state_q == FETCH) || discard_q;
  assign rd_addr = addr_q;
  assign pos     = pos_q;
  assign playing = (state_q != IDLE);
  assign done    = done_q;

endmodule

// File: tb/tb_cassette_player.sv
// Scoreboard bench for cassette_player: expected pulse widths and
// fetch addresses are queued by stimulus and popped by monitors.
module tb_cassette_player;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        play = 1'b0;
  logic        rewind = 1'b0;
  logic        ce_tick = 1'b1;
  logic [23:0] tape_end = '0;
  logic        cass_out;
  logic [23:0] pos;
  logic        playing;
  logic        done;

  cassette_player_if bus();

  logic       mem_ack = 1'b0;
  logic       man_ack = 1'b0;
  logic [7:0] mem_dat = '0;
  logic [7:0] man_dat = '0;
  logic [7:0] mem [16];

  int ack_dly = 0;
  int hold_addr = 16;
  int ce_div = 1;
  int cyc = 0;
  int wcnt = 0;
  int n_cmp = 0;
  int n_bad = 0;
  int n_done = 0;
  int exp_hi[$];
  int exp_addr[$];

`ifdef CASSETTE_LEADER_EN
  localparam int LEAD_N = 4;
`else
  localparam int LEAD_N = 0;
`endif

  assign bus.rd_ack  = mem_ack | man_ack;
  assign bus.rd_data = mem_ack ? mem_dat : man_dat;

  cassette_player #(
    .ZERO_HALF(2),
    .ONE_HALF(1),
    .LEADER_CYCLES(4)
  ) dut (
    .clk_sys (clk),
    .reset_n (reset_n),
    .play    (play),
    .rewind  (rewind),
    .ce_tick (ce_tick),
    .tape_end(tape_end),
    .rd_req  (bus.rd_req),
    .rd_addr (bus.rd_addr),
    .rd_ack  (bus.rd_ack),
    .rd_data (bus.rd_data),
    .cass_out(cass_out),
    .pos     (pos),
    .playing (playing),
    .done    (done)
  );

  initial forever #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic push_byte(input logic [7:0] b, input bit dc0);
    for (int i = 0; i < 8; i++)
      exp_hi.push_back((dc0 && i == 0) ? -1 : (b[i] ? 1 : 2) * ce_div);
  endtask

  task automatic push_leader(input bit dc0);
    for (int i = 0; i < LEAD_N; i++)
      exp_hi.push_back((dc0 && i == 0) ? -1 : ce_div);
  endtask

  task automatic run_until_done(input int lim, input string nm);
    bit got;
    got = 1'b0;
    for (int i = 0; i < lim && !got; i++) begin
      @(negedge clk);
      if (done) got = 1'b1;
    end
    play = 1'b0;
    if (!got) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s_timeout: got no done want done", nm);
    end
  endtask

  // timebase strobe
  initial forever begin
    @(posedge clk);
    #1;
    cyc++;
    ce_tick = (cyc % ce_div) == 0;
  end

  // tape store with programmable ack latency
  initial forever begin
    @(posedge clk);
    #1;
    if (mem_ack) begin
      mem_ack = 1'b0;
      wcnt = 0;
    end else if (reset_n && bus.rd_req &&
                 int'(bus.rd_addr) < hold_addr) begin
      if (wcnt >= ack_dly) begin
        mem_ack = 1'b1;
        mem_dat = mem[bus.rd_addr[3:0]];
      end else begin
        wcnt++;
      end
    end else begin
      wcnt = 0;
    end
  end

  // bit monitor: high-pulse width per bit
  initial begin
    int hi_len;
    int e;
    logic prev_c;
    hi_len = 0;
    prev_c = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        hi_len = 0;
        prev_c = 1'b0;
      end else begin
        if (cass_out) begin
          hi_len++;
        end else if (prev_c) begin
          if (exp_hi.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL bit_unexpected: got hi %0d want none", hi_len);
          end else begin
            e = exp_hi.pop_front();
            if (e >= 0) check("bit_hi_len", hi_len, e);
          end
          hi_len = 0;
        end
        prev_c = cass_out;
      end
    end
  end

  // fetch monitor: address order and handshake stability
  initial begin
    logic p_req, p_ack;
    logic [23:0] p_addr;
    p_req = 1'b0;
    p_ack = 1'b0;
    p_addr = '0;
    forever begin
      @(negedge clk);
      if (done) n_done++;
      if (!reset_n) begin
        p_req = 1'b0;
        p_ack = 1'b0;
      end else begin
        if (p_req && !p_ack) begin
          check("rd_req_held", bus.rd_req, 1);
          check("rd_addr_stable", bus.rd_addr, p_addr);
        end
        if (bus.rd_req && bus.rd_ack) begin
          if (exp_addr.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL fetch_unexpected: got addr %0d want none",
                     bus.rd_addr);
          end else begin
            check("rd_addr", bus.rd_addr, exp_addr.pop_front());
          end
        end
        p_req = bus.rd_req;
        p_ack = bus.rd_ack;
        p_addr = bus.rd_addr;
      end
    end
  end

  initial begin
    int rises;
    bit got;
    logic pc;
    for (int i = 0; i < 16; i++) mem[i] = '0;

    #12;
    check("rst_rd_req", bus.rd_req, 0);
    check("rst_rd_addr", bus.rd_addr, 0);
    check("rst_cass_out", cass_out, 0);
    check("rst_pos", pos, 0);
    check("rst_playing", playing, 0);
    check("rst_done", done, 0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // single byte 0xA5, tape_end=0
    tape_end = 24'd0;
    mem[0] = 8'hA5;
    exp_addr.push_back(0);
    push_leader(0);
    push_byte(8'hA5, 0);
    play = 1'b1;
    run_until_done(200, "a5");
    check("a5_pos", pos, 0);
    check("a5_playing", playing, 0);
    repeat (3) @(negedge clk);
    check("a5_done_once", n_done, 1);
    check("a5_bits_left", exp_hi.size(), 0);

    // three bytes, slow ack
    tape_end = 24'd2;
    mem[0] = 8'h3C;
    mem[1] = 8'h81;
    mem[2] = 8'hFF;
    ack_dly = 5;
    push_leader(0);
    for (int i = 0; i < 3; i++) begin
      exp_addr.push_back(i);
      push_byte(mem[i], 0);
    end
    play = 1'b1;
    run_until_done(1000, "three");
    ack_dly = 0;
    check("three_pos_wrap", pos, 0);
    repeat (3) @(negedge clk);
    check("three_done", n_done, 2);
    check("three_addr_left", exp_addr.size(), 0);

    // pause during bit 3 of 0x0F
    tape_end = 24'd0;
    mem[0] = 8'h0F;
    exp_addr.push_back(0);
    push_leader(0);
    push_byte(8'h0F, 0);
    play = 1'b1;
    rises = 0;
    pc = 1'b0;
    for (int i = 0; i < 300 && rises < LEAD_N + 4; i++) begin
      @(negedge clk);
      if (cass_out && !pc) rises++;
      pc = cass_out;
    end
    play = 1'b0;
    check("pause_reached_bit3", rises, LEAD_N + 4);
    repeat (12) @(negedge clk);
    check("pause_cass_low", cass_out, 0);
    check("pause_pos", pos, 0);
    check("pause_bits_left", exp_hi.size(), 4);
    play = 1'b1;
    run_until_done(300, "resume");
    repeat (3) @(negedge clk);
    check("resume_done", n_done, 3);
    check("resume_bits_left", exp_hi.size(), 0);

    // rewind while fetch of byte 1 is pending
    tape_end = 24'd1;
    mem[0] = 8'h01;
    hold_addr = 1;
    push_leader(0);
    exp_addr.push_back(0);
    push_byte(8'h01, 0);
    exp_addr.push_back(1);
    play = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 300 && !got; i++) begin
      @(negedge clk);
      if (bus.rd_req && bus.rd_addr == 24'd1) got = 1'b1;
    end
    check("rw_fetch1_seen", got, 1);
    play = 1'b0;
    rewind = 1'b1;
    @(negedge clk);
    rewind = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("rw_req_pending", bus.rd_req, 1);
      check("rw_pos", pos, 0);
      check("rw_playing", playing, 0);
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    man_dat = 8'hFF;
    man_ack = 1'b1;
    @(posedge clk);
    #1;
    man_ack = 1'b0;
    @(negedge clk);
    check("rw_req_released", bus.rd_req, 0);
    repeat (20) @(negedge clk);
    check("rw_quiet_bits", exp_hi.size(), 0);
    check("rw_addr_left", exp_addr.size(), 0);
    check("rw_no_done", n_done, 3);
    check("rw_pos_end", pos, 0);
    hold_addr = 16;

    // reset pulse in the middle of a high half-period
    tape_end = 24'd0;
    mem[0] = 8'h00;
    push_leader(0);
    exp_addr.push_back(0);
    push_byte(8'h00, 0);
    play = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      if (cass_out) got = 1'b1;
    end
    check("rst_mid_hi_seen", got, 1);
    #2;
    reset_n = 1'b0;
    #1;
    check("rst_mid_cass", cass_out, 0);
    check("rst_mid_playing", playing, 0);
    check("rst_mid_req", bus.rd_req, 0);
    exp_hi.delete();
    exp_addr.delete();
    play = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    man_dat = 8'hAA;
    man_ack = 1'b1;
    @(posedge clk);
    #1;
    man_ack = 1'b0;
    repeat (5) @(negedge clk);
    check("stray_req", bus.rd_req, 0);
    check("stray_playing", playing, 0);
    check("stray_cass", cass_out, 0);

    mem[0] = 8'h80;
    push_leader(0);
    exp_addr.push_back(0);
    push_byte(8'h80, 0);
    play = 1'b1;
    run_until_done(300, "after_rst");
    repeat (3) @(negedge clk);
    check("after_rst_done", n_done, 4);

    // sparse timebase: one ce_tick every 3 cycles
    ce_div = 3;
    mem[0] = 8'h5A;
    push_leader(1);
    exp_addr.push_back(0);
    push_byte(8'h5A, 1);
    play = 1'b1;
    run_until_done(800, "slow_ce");
    repeat (3) @(negedge clk);
    ce_div = 1;
    check("slow_ce_done", n_done, 5);

    check("end_bits_left", exp_hi.size(), 0);
    check("end_addr_left", exp_addr.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
